// File: rtl/sdes_pkg.sv
// Shared S-DES tables, FSM state type and key-schedule helpers.
// The key-schedule helpers are only referenced when SDES_KEYGEN_EN is defined.
package sdes_pkg;

    typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_t;
    typedef logic [7:0] subkey_t;

    // Permutation tables list source bit positions, numbered 1..N from the MSB.
    localparam int unsigned EP_IDX  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
    localparam int unsigned P4_IDX  [4]  = '{2, 4, 3, 1};
    localparam int unsigned P10_IDX [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int unsigned P8_IDX  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};

    localparam logic [1:0] S0 [4][4] = '{'{2'd1, 2'd0, 2'd3, 2'd2},
                                         '{2'd3, 2'd2, 2'd1, 2'd0},
                                         '{2'd0, 2'd2, 2'd1, 2'd3},
                                         '{2'd3, 2'd1, 2'd3, 2'd2}};
    localparam logic [1:0] S1 [4][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3},
                                         '{2'd2, 2'd0, 2'd1, 2'd3},
                                         '{2'd3, 2'd0, 2'd1, 2'd0},
                                         '{2'd2, 2'd1, 2'd0, 2'd3}};

    function automatic logic [9:0] p10(input logic [9:0] v);
        logic [9:0] r;
        for (int unsigned i = 0; i < 10; i++) r[9-i] = v[10-P10_IDX[i]];
        return r;
    endfunction

    function automatic subkey_t p8(input logic [9:0] v);
        subkey_t r;
        for (int unsigned i = 0; i < 8; i++) r[7-i] = v[10-P8_IDX[i]];
        return r;
    endfunction

    // Rotate each 5-bit half left by one.
    function automatic logic [9:0] ls1(input logic [9:0] v);
        return {v[8:5], v[9], v[3:0], v[4]};
    endfunction

    function automatic subkey_t keygen_k1(input logic [9:0] key);
        return p8(ls1(p10(key)));
    endfunction

    function automatic subkey_t keygen_k2(input logic [9:0] key);
        return p8(ls1(ls1(ls1(p10(key)))));
    endfunction

endpackage

// File: rtl/sdes_f_func.sv
// Combinational S-DES round function F(R, SK): E/P, key mix, S0/S1, P4.
module sdes_f_func
    import sdes_pkg::*;
(
    input  logic    [3:0] r,
    input  subkey_t       sk,
    output logic    [3:0] f
);

    logic [7:0] ep;
    logic [7:0] x;
    logic [3:0] s_out;

    always_comb begin
        ep = '0;
        for (int unsigned i = 0; i < 8; i++) ep[7-i] = r[4-EP_IDX[i]];
        x = ep ^ sk;
        // Row = {b1,b4}, column = {b2,b3} of each nibble.
        s_out = {S0[{x[7], x[4]}][{x[6], x[5]}], S1[{x[3], x[0]}][{x[2], x[1]}]};
        f = '0;
        for (int unsigned i = 0; i < 4; i++) f[3-i] = s_out[4-P4_IDX[i]];
    end

endmodule

// File: rtl/sdes_fk_engine.sv
// Iterative S-DES round engine: fk(SKa), SW, fk(SKb), one round per clock.
// Define SDES_KEYGEN_EN to take a raw 10-bit key instead of precomputed subkeys.
module sdes_fk_engine
    import sdes_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_signal,
    input  logic       i_decrypt,
`ifdef SDES_KEYGEN_EN
    input  logic [9:0] i_key,
`else
    input  logic [7:0] i_k1,
    input  logic [7:0] i_k2,
`endif
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_signal
);

    state_t     state, state_nxt;
    logic [7:0] lr;
    logic       dec;
    logic       accept;
    subkey_t    k1, k2, sk;
    logic [3:0] f_out;

    assign accept = i_valid && (state == IDLE);

`ifdef SDES_KEYGEN_EN
    logic [9:0] key_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    key_q <= '0;
        else if (accept) key_q <= i_key;
    end

    always_comb begin
        k1 = keygen_k1(key_q);
        k2 = keygen_k2(key_q);
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k1 <= '0;
            k2 <= '0;
        end else if (accept) begin
            k1 <= i_k1;
            k2 <= i_k2;
        end
    end
`endif

    // K1 is used in R1 for encrypt and in R2 for decrypt.
    assign sk = ((state == R1) ^ dec) ? k1 : k2;

    sdes_f_func u_f (
        .r  (lr[3:0]),
        .sk (sk),
        .f  (f_out)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lr  <= '0;
            dec <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    lr  <= i_signal;
                    dec <= i_decrypt;
                end
                R1:      lr <= {lr[3:0], lr[7:4] ^ f_out};
                R2:      lr <= {lr[7:4] ^ f_out, lr[3:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = R1;
            R1:      state_nxt = R2;
            R2:      state_nxt = DONE;
            DONE:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready  = (state == IDLE);
        o_valid  = (state == DONE);
        o_signal = (state == DONE) ? lr : '0;
    end

endmodule

// File: tb/tb_sdes_fk_engine.sv
// Self-checking bench for sdes_fk_engine (builds with or without SDES_KEYGEN_EN).
module tb_sdes_fk_engine;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_signal;
    logic       i_decrypt;
    logic [9:0] i_key;
    logic [7:0] i_k1, i_k2;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_signal;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    sdes_fk_engine dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_signal  (i_signal),
        .i_decrypt (i_decrypt),
`ifdef SDES_KEYGEN_EN
        .i_key     (i_key),
`else
        .i_k1      (i_k1),
        .i_k2      (i_k2),
`endif
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_signal  (o_signal)
    );

    // Reference model: straight from the S-DES definition, using index strings
    // ('A' = position 10) and flat S-box lookup tables.
    int unsigned S0_T [16] = '{1,0,3,2, 3,2,1,0, 0,2,1,3, 3,1,3,2};
    int unsigned S1_T [16] = '{0,1,2,3, 2,0,1,3, 3,0,1,0, 2,1,0,3};

    function automatic int unsigned perm(input int unsigned v, input int unsigned n, input string tbl);
        int unsigned res = 0;
        int unsigned p;
        for (int i = 0; i < tbl.len(); i++) begin
            p = (tbl[i] == "A") ? 10 : int'(tbl[i]) - int'("0");
            res = (res << 1) | ((v >> (n - p)) & 1);
        end
        return res;
    endfunction

    function automatic int unsigned rotl5(input int unsigned x, input int unsigned n);
        return ((x << n) | (x >> (5 - n))) & 31;
    endfunction

    function automatic void ref_keys(input int unsigned key, output logic [7:0] k1, output logic [7:0] k2);
        int unsigned p, l, r;
        p = perm(key, 10, "35274A1986");
        l = rotl5(p >> 5, 1);
        r = rotl5(p & 31, 1);
        k1 = 8'(perm((l << 5) | r, 10, "637485A9"));
        l = rotl5(l, 2);
        r = rotl5(r, 2);
        k2 = 8'(perm((l << 5) | r, 10, "637485A9"));
    endfunction

    function automatic int unsigned f_ref(input int unsigned r, input int unsigned sk);
        int unsigned e, a, b, s;
        e = perm(r, 4, "41232341") ^ sk;
        a = e >> 4;
        b = e & 15;
        s = S0_T[(((a >> 3) & 1) * 2 + (a & 1)) * 4 + ((a >> 1) & 3)] * 4
          + S1_T[(((b >> 3) & 1) * 2 + (b & 1)) * 4 + ((b >> 1) & 3)];
        return perm(s, 4, "2431");
    endfunction

    function automatic logic [7:0] sdes_ref(input logic [7:0] blk, input logic dec,
                                            input logic [7:0] k1, input logic [7:0] k2);
        int unsigned l, r, t, ska, skb;
        ska = dec ? k2 : k1;
        skb = dec ? k1 : k2;
        l = blk >> 4;
        r = blk & 15;
        t = l ^ f_ref(r, ska);
        l = r;
        r = t;
        l = l ^ f_ref(r, skb);
        return 8'((l << 4) | r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_keys(input logic [9:0] key, input logic [7:0] k1, input logic [7:0] k2);
        i_key = key;
        i_k1  = k1;
        i_k2  = k2;
    endtask

    // Starts from IDLE, #1 after a rising edge; returns in IDLE, #1 after an edge.
    task automatic run_block(input string tag, input logic [7:0] blk, input logic dec,
                             input logic [9:0] key, input logic [7:0] k1, input logic [7:0] k2,
                             input logic [7:0] exp, input int unsigned hold, input bit disturb);
        int unsigned cyc = 0;
        bit          stable = 1;
        logic [7:0]  held;
        check({tag, " idle_ready"}, o_ready, 1);
        i_valid   = 1'b1;
        i_signal  = blk;
        i_decrypt = dec;
        i_ready   = 1'b0;
        drive_keys(key, k1, k2);
        do begin
            @(posedge i_clk); #1;
            cyc++;
            if (disturb) begin
                i_valid   = 1'b1;
                i_signal  = 8'($urandom);
                i_decrypt = ~dec;
                drive_keys(10'($urandom), 8'($urandom), 8'($urandom));
            end else begin
                i_valid = 1'b0;
            end
        end while (!o_valid && cyc < 10);
        i_valid = 1'b0;
        check({tag, " latency"}, cyc, 3);
        check({tag, " busy_ready"}, o_ready, 0);
        check({tag, " result"}, o_signal, exp);
        held = o_signal;
        repeat (hold) begin
            @(posedge i_clk); #1;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_signal !== held) stable = 0;
        end
        if (hold > 0) check({tag, " hold_stable"}, stable, 1);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check({tag, " release"}, {o_valid, o_ready, o_signal}, {1'b0, 1'b1, 8'h00});
    endtask

    typedef struct {
        logic [7:0]  blk;
        logic        dec;
        logic [9:0]  key;
        logic [7:0]  k1;
        logic [7:0]  k2;
        logic [7:0]  exp;
        int unsigned hold;
        bit          disturb;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  k1, k2, blk, exp;
        logic [9:0]  key;
        logic        dec;
        int unsigned vcnt, overlap, tp_bad;

        vecs[0] = '{8'b01011101, 1'b0, 10'b1010000010, 8'b10100100, 8'b01000011, 8'b00101010, 0, 0};
        vecs[1] = '{8'b00101010, 1'b1, 10'b1010000010, 8'b10100100, 8'b01000011, 8'b01011101, 5, 0};
        vecs[2] = '{8'b01011101, 1'b0, 10'b1010000010, 8'b10100100, 8'b01000011, 8'b00101010, 2, 1};
        vecs[3] = '{8'b00101010, 1'b1, 10'b1010000010, 8'b10100100, 8'b01000011, 8'b01011101, 1, 1};

        i_rst_n = 1'b0; i_valid = 1'b0; i_signal = '0; i_decrypt = 1'b0;
        i_ready = 1'b0; drive_keys('0, '0, '0);
        #2;
        check("reset_state", {o_valid, o_ready, o_signal}, {1'b0, 1'b1, 8'h00});
        #10 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("post_reset", {o_valid, o_ready, o_signal}, {1'b0, 1'b1, 8'h00});

        for (int i = 0; i < 4; i++)
            run_block($sformatf("vec%0d", i), vecs[i].blk, vecs[i].dec, vecs[i].key,
                      vecs[i].k1, vecs[i].k2, vecs[i].exp, vecs[i].hold, vecs[i].disturb);

        // Reset while in R2: aborts immediately, then a fresh block must complete.
        i_valid = 1'b1; i_signal = vecs[0].blk; i_decrypt = 1'b0;
        drive_keys(vecs[0].key, vecs[0].k1, vecs[0].k2);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        check("rst_r2_now", {o_valid, o_ready, o_signal}, {1'b0, 1'b1, 8'h00});
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_r2_held", {o_valid, o_ready, o_signal}, {1'b0, 1'b1, 8'h00});
        i_rst_n = 1'b1;
        run_block("after_rst", vecs[0].blk, 1'b0, vecs[0].key, vecs[0].k1, vecs[0].k2,
                  vecs[0].exp, 0, 0);

        // Randomised blocks against the reference model.
        for (int n = 0; n < 30; n++) begin
            blk = 8'($urandom);
            dec = 1'($urandom);
            key = 10'($urandom);
`ifdef SDES_KEYGEN_EN
            ref_keys(key, k1, k2);
`else
            k1 = 8'($urandom);
            k2 = 8'($urandom);
`endif
            exp = sdes_ref(blk, dec, k1, k2);
            run_block($sformatf("rnd%0d", n), blk, dec, key, k1, k2, exp,
                      $urandom_range(0, 3), 1'($urandom));
        end

        // Streaming with i_ready high: one result every four cycles.
        blk = 8'h3C; key = 10'h2D5;
        ref_keys(key, k1, k2);
        exp = sdes_ref(blk, 1'b0, k1, k2);
        i_valid = 1'b1; i_ready = 1'b1; i_signal = blk; i_decrypt = 1'b0;
        drive_keys(key, k1, k2);
        vcnt = 0; overlap = 0; tp_bad = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                vcnt++;
                if (o_signal !== exp) tp_bad++;
            end
            if (o_valid && o_ready) overlap++;
        end
        i_valid = 1'b0; i_ready = 1'b0;
        check("stream_count", vcnt, 4);
        check("stream_overlap", overlap, 0);
        check("stream_data", tp_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdes_fk_engine.md
# sdes_fk_engine

Iterative S-DES round engine that sits directly downstream of the initial permutation (IP) stage. It accepts one IP-permuted 8-bit block and applies fk(K1), SW and fk(K2), one round per clock, with K1 and K2 swapped for decryption. Its output is the 8-bit pre-IP⁻¹ value consumed by the inverse-permutation stage. A valid/ready handshake is used on both sides.

## Interface
Parameters: none.
- i_clk  input  1  system clock; all state updates on rising edge
- i_rst_n  input  1  reset; asynchronous, active-low
- i_valid  input  1  upstream block valid
- o_ready  output  1  engine can accept a block
- i_signal  input  8  IP-permuted block; [7:4]=L, [3:0]=R
- i_decrypt  input  1  0=encrypt (K1 then K2), 1=decrypt (K2 then K1)
- i_key  input  10  raw S-DES key, bit 9 = key bit 1 (present only with SDES_KEYGEN_EN)
- i_k1, i_k2  input  8 each  precomputed subkeys (present only without SDES_KEYGEN_EN)
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_signal  output  8  result after fk(K2)∘SW∘fk(K1), with no IP⁻¹ applied

## Operation
- The FSM has four states: IDLE → R1 → R2 → DONE → IDLE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: latch i_signal into {L,R}, latch the mode, and latch the key or subkeys.
  - Go to R1.
- R1: {L,R} ← {R, L⊕F(R,SKa)}. This is fk followed by SW. Go to R2.
- R2: {L,R} ← {L⊕F(R,SKb), R}, with no swap. Go to DONE.
- DONE:
  - o_valid=1 and o_signal={L,R}.
  - On i_ready: go to IDLE.
  - o_signal and o_valid stay stable until the handshake completes.
- Subkey order: for encrypt, SKa=K1 and SKb=K2; for decrypt, SKa=K2 and SKb=K1.
- F(R,SK), with bits numbered 1..4 MSB-first:
  - E/P = [4 1 2 3 2 3 4 1].
  - XOR the E/P result with SK.
  - The left nibble goes to S0 and the right nibble goes to S1. Row = {b1,b4}, column = {b2,b3}.
  - Apply P4 = [2 4 3 1].
- S-box contents:
  - S0 rows = {1,0,3,2},{3,2,1,0},{0,2,1,3},{3,1,3,2}.
  - S1 rows = {0,1,2,3},{2,0,1,3},{3,0,1,0},{2,1,0,3}.
- Key schedule (with SDES_KEYGEN_EN):
  - P10 = [3 5 2 7 4 10 1 9 8 6], then split into 5-bit halves.
  - LS-1 on each half, then P8 = [6 3 7 4 8 5 10 9] gives K1.
  - A further LS-2 on each half, then P8, gives K2.
- Inputs are ignored in every state other than IDLE. Changes to i_key or i_decrypt mid-block have no effect.
- Asynchronous reset mid-operation:
  - Aborts the block immediately. No partial result is emitted.
  - State returns to IDLE, with o_valid=0, o_ready=1, o_signal=8'h00.

## Timing
- Reset values: o_ready=1, o_valid=0, o_signal=8'h00.
- Latency: accept in cycle N; o_valid is asserted in cycle N+3 (registered after the R2 update).
- Throughput: one block per 4 cycles with i_ready held high. Back-pressure extends DONE indefinitely.
- o_ready is a pure function of state (IDLE only), so there is no combinational path from i_ready to o_ready.
- Accept and completion never occur in the same cycle.

## Configuration
- SDES_KEYGEN_EN defined:
  - The i_key port and the internal P10/LS/P8 schedule are compiled in.
  - The 10-bit key is latched on accept. K1 and K2 are derived combinationally from the latched key.
- SDES_KEYGEN_EN undefined:
  - The i_k1 and i_k2 ports are compiled in and latched on accept. There is no key-schedule logic.
  - The engine is still responsible for swapping K1/K2 in decrypt mode.

## Structure
- Package sdes_pkg holds:
  - S0/S1 tables, E/P, P4, P10 and P8 index constants;
  - the state enum (IDLE, R1, R2, DONE);
  - a subkey typedef.
- Sub-module sdes_f_func implements F(R,SK) combinationally (4-bit R, 8-bit SK, 4-bit result). It is instantiated once and shared by R1 and R2 via a subkey mux.

## Test plan
- Encrypt, with SDES_KEYGEN_EN defined: key=10'b1010000010, i_signal=8'b01011101, i_decrypt=0.
  - o_signal=8'b00101010 three cycles after accept.
  - Internal K1=8'b10100100 and K2=8'b01000011.
- Decrypt: same key, i_signal=8'b00101010, i_decrypt=1 → o_signal=8'b01011101.
- Without SDES_KEYGEN_EN: i_k1=8'b10100100, i_k2=8'b01000011, i_signal=8'b01011101, encrypt → 8'b00101010.
- Back-pressure: hold i_ready=0 for 5 cycles in DONE.
  - o_signal and o_valid stay stable and o_ready=0.
  - When i_ready rises: o_valid drops next cycle and o_ready returns.
- Input stability: change i_key, i_decrypt and i_signal during R1 and R2 → result is unchanged. i_valid while busy → no second accept.
- Reset during R2: assert i_rst_n=0.
  - o_valid=0, o_ready=1, o_signal=8'h00 immediately.
  - After release, a fresh block completes with the correct result.
